// File: rtl/bram_be_stream_dp.sv
// Byte-enable dual-port RAM with valid/ready request and response ports.
// Each port: credit counter, fixed-latency read pipeline and an in-order response FIFO.
module bram_be_stream_dp #(
  parameter int  NB_COL       = 4,
  parameter int  COL_WIDTH    = 8,
  parameter int  RAM_DEPTH    = 1024,
  parameter int  READ_LATENCY = 2,
  parameter      RDW_MODE     = "WRITE_FIRST",
  parameter      INIT_FILE    = "",
  localparam int AW           = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int DW           = NB_COL * COL_WIDTH
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              req_valid_a_i,
  output logic              req_ready_a_o,
  input  logic [NB_COL-1:0] we_a_i,
  input  logic [AW-1:0]     addr_a_i,
  input  logic [DW-1:0]     din_a_i,
  output logic              rsp_valid_a_o,
  input  logic              rsp_ready_a_i,
  output logic [DW-1:0]     dout_a_o,
  input  logic              req_valid_b_i,
  output logic              req_ready_b_o,
  input  logic [NB_COL-1:0] we_b_i,
  input  logic [AW-1:0]     addr_b_i,
  input  logic [DW-1:0]     din_b_i,
  output logic              rsp_valid_b_o,
  input  logic              rsp_ready_b_i,
  output logic [DW-1:0]     dout_b_o,
  output logic              collision_o
);

  localparam int          FD      = READ_LATENCY + 1;
  localparam int          CW      = $clog2(FD + 1);
  localparam int          PW      = $clog2(FD);
  localparam logic [AW:0] DEPTH_W = RAM_DEPTH[AW:0];
  localparam bit          WF      = (RDW_MODE == "WRITE_FIRST");

  logic [DW-1:0]     mem [RAM_DEPTH];
  logic [1:0]        req_valid, req_ready, acc, rsp_ready, rsp_valid, in_range;
  logic [NB_COL-1:0] we   [2];
  logic [AW-1:0]     addr [2];
  logic [DW-1:0]     din  [2];
  logic [DW-1:0]     dout [2];
  logic              rst_done_q;
  logic              coll_q;

  assign req_valid = {req_valid_b_i, req_valid_a_i};
  assign rsp_ready = {rsp_ready_b_i, rsp_ready_a_i};
  assign we[0]     = we_a_i;
  assign we[1]     = we_b_i;
  assign addr[0]   = addr_a_i;
  assign addr[1]   = addr_b_i;
  assign din[0]    = din_a_i;
  assign din[1]    = din_b_i;

  initial begin
    for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) rst_done_q <= 1'b0;
    else         rst_done_q <= 1'b1;
  end

  // Port A owns overlapping lanes when both ports hit the same word.
  always_ff @(posedge clk_i) begin
    for (int l = 0; l < NB_COL; l++) begin
      if (acc[0] && in_range[0] && we[0][l])
        mem[addr[0]][l*COL_WIDTH +: COL_WIDTH] <= din[0][l*COL_WIDTH +: COL_WIDTH];
      if (acc[1] && in_range[1] && we[1][l] &&
          !(acc[0] && in_range[0] && we[0][l] && (addr[0] == addr[1])))
        mem[addr[1]][l*COL_WIDTH +: COL_WIDTH] <= din[1][l*COL_WIDTH +: COL_WIDTH];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) coll_q <= 1'b0;
    else         coll_q <= acc[0] && acc[1] && in_range[0] && in_range[1] &&
                           (addr[0] == addr[1]) && (|(we[0] & we[1]));
  end
  assign collision_o = coll_q;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] fc_q;
    logic [PW-1:0] wp_q, rp_q;
    logic [DW-1:0] fm [FD];
    logic [DW-1:0] rd_l;
    logic          push_v, pop;
    logic [DW-1:0] push_d;

    assign in_range[p]  = ({1'b0, addr[p]} < DEPTH_W);
    assign req_ready[p] = rst_done_q && rstn_i && (cnt_q < CW'(FD));
    assign acc[p]       = req_valid[p] && req_ready[p];
    assign pop          = rsp_valid[p] && rsp_ready[p];

    // Array is sampled before this cycle's writes land, so the other port sees old data.
    always_comb begin
      rd_l = in_range[p] ? mem[addr[p]] : '0;
      if (WF && in_range[p]) begin
        for (int l = 0; l < NB_COL; l++)
          if (we[p][l]) rd_l[l*COL_WIDTH +: COL_WIDTH] = din[p][l*COL_WIDTH +: COL_WIDTH];
      end
    end

    always_ff @(posedge clk_i) begin
      if (!rstn_i)               cnt_q <= '0;
      else if (acc[p] && !pop)   cnt_q <= cnt_q + 1'b1;
      else if (!acc[p] && pop)   cnt_q <= cnt_q - 1'b1;
    end

    if (READ_LATENCY == 1) begin : g_nopipe
      assign push_v = acc[p];
      assign push_d = rd_l;
    end else begin : g_pipe
      logic          pv [READ_LATENCY-1];
      logic [DW-1:0] pd [READ_LATENCY-1];
      always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
          for (int i = 0; i < READ_LATENCY-1; i++) pv[i] <= 1'b0;
        end else begin
          pv[0] <= acc[p];
          for (int i = 1; i < READ_LATENCY-1; i++) pv[i] <= pv[i-1];
        end
      end
      always_ff @(posedge clk_i) begin
        pd[0] <= rd_l;
        for (int i = 1; i < READ_LATENCY-1; i++) pd[i] <= pd[i-1];
      end
      assign push_v = pv[READ_LATENCY-2];
      assign push_d = pd[READ_LATENCY-2];
    end

    always_ff @(posedge clk_i) begin
      if (push_v) fm[wp_q] <= push_d;
    end

    always_ff @(posedge clk_i) begin
      if (!rstn_i) begin
        wp_q <= '0;
        rp_q <= '0;
        fc_q <= '0;
      end else begin
        if (push_v) wp_q <= (wp_q == PW'(FD-1)) ? '0 : wp_q + 1'b1;
        if (pop)    rp_q <= (rp_q == PW'(FD-1)) ? '0 : rp_q + 1'b1;
        if (push_v && !pop)      fc_q <= fc_q + 1'b1;
        else if (!push_v && pop) fc_q <= fc_q - 1'b1;
      end
    end

    assign rsp_valid[p] = (fc_q != '0);
    assign dout[p]      = rsp_valid[p] ? fm[rp_q] : '0;
  end

  assign req_ready_a_o = req_ready[0];
  assign req_ready_b_o = req_ready[1];
  assign rsp_valid_a_o = rsp_valid[0];
  assign rsp_valid_b_o = rsp_valid[1];
  assign dout_a_o      = dout[0];
  assign dout_b_o      = dout[1];

endmodule

// File: tb/tb_bram_be_stream_dp.sv
// Directed bench for bram_be_stream_dp: a WRITE_FIRST and a READ_FIRST instance share stimulus.
module tb_bram_be_stream_dp;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
  logic        rsp_ready_a = 1'b1, rsp_ready_b = 1'b1;
  logic [3:0]  we_a = '0, we_b = '0;
  logic [9:0]  addr_a = '0, addr_b = '0;
  logic [31:0] din_a = '0, din_b = '0;

  logic        req_ready_a, req_ready_b, rsp_valid_a, rsp_valid_b, collision;
  logic [31:0] dout_a, dout_b;
  logic        req_ready_a_rf, req_ready_b_rf, rsp_valid_a_rf, rsp_valid_b_rf, collision_rf;
  logic [31:0] dout_a_rf, dout_b_rf;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  bram_be_stream_dp #(.RAM_DEPTH(1000), .READ_LATENCY(2), .RDW_MODE("WRITE_FIRST")) dut (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_a_i(req_valid_a), .req_ready_a_o(req_ready_a), .we_a_i(we_a),
    .addr_a_i(addr_a), .din_a_i(din_a), .rsp_valid_a_o(rsp_valid_a),
    .rsp_ready_a_i(rsp_ready_a), .dout_a_o(dout_a),
    .req_valid_b_i(req_valid_b), .req_ready_b_o(req_ready_b), .we_b_i(we_b),
    .addr_b_i(addr_b), .din_b_i(din_b), .rsp_valid_b_o(rsp_valid_b),
    .rsp_ready_b_i(rsp_ready_b), .dout_b_o(dout_b),
    .collision_o(collision)
  );

  bram_be_stream_dp #(.RAM_DEPTH(1000), .READ_LATENCY(2), .RDW_MODE("READ_FIRST")) u_rf (
    .clk_i(clk), .rstn_i(rstn),
    .req_valid_a_i(req_valid_a), .req_ready_a_o(req_ready_a_rf), .we_a_i(we_a),
    .addr_a_i(addr_a), .din_a_i(din_a), .rsp_valid_a_o(rsp_valid_a_rf),
    .rsp_ready_a_i(rsp_ready_a), .dout_a_o(dout_a_rf),
    .req_valid_b_i(req_valid_b), .req_ready_b_o(req_ready_b_rf), .we_b_i(we_b),
    .addr_b_i(addr_b), .din_b_i(din_b), .rsp_valid_b_o(rsp_valid_b_rf),
    .rsp_ready_b_i(rsp_ready_b), .dout_b_o(dout_b_rf),
    .collision_o(collision_rf)
  );

  typedef struct {
    logic [3:0]  we;
    logic [9:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_wf;
    logic [31:0] exp_rf;
    string       nm;
  } vec_t;

  vec_t tv [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] dpat(input int i);
    return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
  endfunction

  // One request per enabled port in the same cycle; response expected exactly 2 cycles later.
  task automatic xfer(input bit va, input logic [3:0] wa, input logic [9:0] aa, input logic [31:0] da,
                      input bit vb, input logic [3:0] wb, input logic [9:0] ab, input logic [31:0] db,
                      input logic [31:0] ea, input logic [31:0] ea_rf,
                      input logic [31:0] eb, input logic [31:0] eb_rf,
                      input bit ecoll, input string nm);
    @(negedge clk);
    req_valid_a = va; we_a = wa; addr_a = aa; din_a = da;
    req_valid_b = vb; we_b = wb; addr_b = ab; din_b = db;
    if (va) chk({nm, " ready_a"}, req_ready_a, 1'b1);
    if (vb) chk({nm, " ready_b"}, req_ready_b, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req_valid_a = 1'b0; req_valid_b = 1'b0;
    chk({nm, " coll_n1"}, collision, ecoll);
    if (va) chk({nm, " early_a"}, rsp_valid_a, 1'b0);
    if (vb) chk({nm, " early_b"}, rsp_valid_b, 1'b0);
    @(negedge clk);
    chk({nm, " coll_n2"}, collision, 1'b0);
    if (va) begin
      chk({nm, " valid_a"}, rsp_valid_a, 1'b1);
      chk({nm, " dout_a"}, dout_a, ea);
      chk({nm, " dout_a_rf"}, dout_a_rf, ea_rf);
    end
    if (vb) begin
      chk({nm, " valid_b"}, rsp_valid_b, 1'b1);
      chk({nm, " dout_b"}, dout_b, eb);
      chk({nm, " dout_b_rf"}, dout_b_rf, eb_rf);
    end
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " rsp_valid_a"}, rsp_valid_a, 1'b0);
    chk({nm, " rsp_valid_b"}, rsp_valid_b, 1'b0);
    chk({nm, " dout_a"}, dout_a, 32'h0);
    chk({nm, " dout_b"}, dout_b, 32'h0);
    chk({nm, " collision"}, collision, 1'b0);
    chk({nm, " ready_a"}, req_ready_a, 1'b0);
    chk({nm, " ready_b"}, req_ready_b, 1'b0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({nm, " ready_a_rel"}, req_ready_a, 1'b1);
    chk({nm, " ready_b_rel"}, req_ready_b, 1'b1);
    chk({nm, " rsp_valid_a_rel"}, rsp_valid_a, 1'b0);
  endtask

  // 16 back-to-back requests to 16..31 on port A with rsp_ready held high.
  task automatic b2b(input bit wr, input string nm);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 18) begin
        chk($sformatf("%s valid[%0d]", nm, c-2), rsp_valid_a, 1'b1);
        chk($sformatf("%s dout[%0d]", nm, c-2), dout_a, dpat(c-2));
      end
      if (c < 16) begin
        chk($sformatf("%s ready[%0d]", nm, c), req_ready_a, 1'b1);
        req_valid_a = 1'b1;
        we_a = wr ? 4'hF : 4'h0;
        addr_a = 10'(16 + c);
        din_a = dpat(c);
      end else begin
        req_valid_a = 1'b0;
      end
    end
  endtask

  initial begin
    int acc;
    int n;
    logic [31:0] got [8];
    logic rdy;

    tv[0]  = '{4'hF, 10'd5,    32'hDEADBEEF, 32'hDEADBEEF, 32'h00000000, "wr5"};
    tv[1]  = '{4'h0, 10'd5,    32'h0,        32'hDEADBEEF, 32'hDEADBEEF, "rd5"};
    tv[2]  = '{4'hF, 10'd7,    32'h11223344, 32'h11223344, 32'h00000000, "wr7"};
    tv[3]  = '{4'h3, 10'd7,    32'hAAAABBBB, 32'h1122BBBB, 32'h11223344, "rdw7"};
    tv[4]  = '{4'h0, 10'd7,    32'h0,        32'h1122BBBB, 32'h1122BBBB, "rd7"};
    tv[5]  = '{4'h8, 10'd3,    32'h5A000000, 32'h5A000000, 32'h00000000, "wr3_lane3"};
    tv[6]  = '{4'h0, 10'd3,    32'h0,        32'h5A000000, 32'h5A000000, "rd3"};
    tv[7]  = '{4'hF, 10'd999,  32'h01020304, 32'h01020304, 32'h00000000, "wr999"};
    tv[8]  = '{4'hF, 10'd1000, 32'hCAFEF00D, 32'h00000000, 32'h00000000, "wr1000_oor"};
    tv[9]  = '{4'h0, 10'd1000, 32'h0,        32'h00000000, 32'h00000000, "rd1000_oor"};
    tv[10] = '{4'h0, 10'd999,  32'h0,        32'h01020304, 32'h01020304, "rd999"};
    tv[11] = '{4'h0, 10'd0,    32'h0,        32'h00000000, 32'h00000000, "rd0"};
    tv[12] = '{4'hF, 10'd9,    32'h77665544, 32'h77665544, 32'h00000000, "wr9"};

    do_reset("rst0");

    for (int i = 0; i < 13; i++)
      xfer(1'b1, tv[i].we, tv[i].addr, tv[i].din, 1'b0, 4'h0, 10'd0, 32'h0,
           tv[i].exp_wf, tv[i].exp_rf, 32'h0, 32'h0, 1'b0, tv[i].nm);

    b2b(1'b1, "b2b_wr");
    b2b(1'b0, "b2b_rd");

    // Backpressure: only READ_LATENCY+1 requests may be outstanding.
    @(negedge clk);
    rsp_ready_a = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      req_valid_a = 1'b1; we_a = 4'h0; addr_a = 10'(16 + acc);
      rdy = req_ready_a;
      @(posedge clk);
      if (rdy) acc++;
      @(negedge clk);
    end
    req_valid_a = 1'b0;
    chk("bp accepted", 32'(acc), 32'd3);
    chk("bp ready_low", req_ready_a, 1'b0);
    chk("bp hold_valid", rsp_valid_a, 1'b1);
    chk("bp hold_dout0", dout_a, dpat(0));
    @(negedge clk);
    @(negedge clk);
    chk("bp hold_dout1", dout_a, dpat(0));
    rsp_ready_a = 1'b1;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (rsp_valid_a && n < 8) begin
        got[n] = dout_a;
        n++;
      end
      @(negedge clk);
    end
    chk("bp rsp_count", 32'(n), 32'd3);
    for (int i = 0; i < 3; i++) chk($sformatf("bp order[%0d]", i), got[i], dpat(i));
    chk("bp ready_back", req_ready_a, 1'b1);

    // Same-address dual-port cases on word 9 (holds 0x77665544).
    xfer(1'b1, 4'h3, 10'd9, 32'h0000AAAA, 1'b1, 4'h6, 10'd9, 32'h00BBBB00,
         32'h7766AAAA, 32'h77665544, 32'h77BBBB44, 32'h77665544, 1'b1, "coll_ovl");
    xfer(1'b1, 4'h0, 10'd9, 32'h0, 1'b0, 4'h0, 10'd0, 32'h0,
         32'h77BBAAAA, 32'h77BBAAAA, 32'h0, 32'h0, 1'b0, "rd9_merge");
    xfer(1'b1, 4'h1, 10'd9, 32'h000000CC, 1'b1, 4'h0, 10'd9, 32'h0,
         32'h77BBAACC, 32'h77BBAAAA, 32'h77BBAAAA, 32'h77BBAAAA, 1'b0, "xport_rdw");
    xfer(1'b1, 4'h8, 10'd9, 32'h11000000, 1'b1, 4'h1, 10'd9, 32'h00000022,
         32'h11BBAACC, 32'h77BBAACC, 32'h77BBAA22, 32'h77BBAACC, 1'b0, "coll_noovl");
    xfer(1'b0, 4'h0, 10'd0, 32'h0, 1'b1, 4'h0, 10'd9, 32'h0,
         32'h0, 32'h0, 32'h11BBAA22, 32'h11BBAA22, 1'b0, "rd9_b");

    // Mid-stream reset with responses pending.
    @(negedge clk);
    rsp_ready_a = 1'b0;
    req_valid_a = 1'b1; we_a = 4'h0; addr_a = 10'd7;
    @(negedge clk);
    @(negedge clk);
    req_valid_a = 1'b0;
    @(negedge clk);
    chk("mid pending", rsp_valid_a, 1'b1);
    do_reset("rst_mid");
    rsp_ready_a = 1'b1;
    xfer(1'b1, 4'h0, 10'd5, 32'h0, 1'b1, 4'h0, 10'd7, 32'h0,
         32'hDEADBEEF, 32'hDEADBEEF, 32'h1122BBBB, 32'h1122BBBB, 1'b0, "post_rst");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
